// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
//   Shared definitions for the Async_fifo write-port arbiter:
//     - arb_state_e : FSM encoding (ST_IDLE / ST_XFER)
//     - clog2()     : width helper, never returns less than 1 so that
//                     single-value counters still get a real bit
//   Derived widths used by the top level:
//     PTR_W = clog2(NUM_REQ), CNT_W = clog2(BURST_LEN+1)
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// ---------------------------------------------------------------------------
// arb_rr_pick
//   Combinational round-robin winner selection.
//   The request vector is rotated right by i_ptr (via a double-width copy),
//   the lowest set bit is isolated, and the one-hot result is rotated back.
//   The winner is therefore the first requester at or above i_ptr, wrapping.
// Ports
//   i_req    [NUM_REQ]  request vector
//   i_ptr    [PTR_W]    search start index (must be < NUM_REQ)
//   o_winner [NUM_REQ]  one-hot winner, 0 when no request
//   o_valid             at least one request present
// ---------------------------------------------------------------------------
module arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_winner,
    output logic               o_valid
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [NUM_REQ-1:0]   w_rot_oh;
    logic [2*NUM_REQ-1:0] w_back;

    // Bit j of w_rot is req[(j + ptr) mod NUM_REQ].
    assign w_dbl    = {i_req, i_req} >> i_ptr;
    assign w_rot    = w_dbl[NUM_REQ-1:0];
    // Isolate the lowest set bit (two's complement trick).
    assign w_rot_oh = w_rot & (~w_rot + NUM_REQ'(1));
    // Rotate left by ptr; the upper half holds the wrapped result.
    assign w_back   = {w_rot_oh, w_rot_oh} << i_ptr;
    assign o_winner = w_back[2*NUM_REQ-1:NUM_REQ];
    assign o_valid  = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the Async_fifo write port among NUM_REQ producers (wclk domain).
//   One producer is granted at a time for a burst of up to BURST_LEN words.
//
// Handshake: req[i] is the producer's valid; a word moves on a cycle where
//   ack[i]=1 (granted, valid, FIFO not full). The producer must hold its
//   word/last until acked; ack and wr_en are combinational in that cycle.
//
// Ports
//   wclk, rst_n        clock, asynchronous active-low reset
//   req      [N]       per-producer valid
//   req_data [N*D]     slice i = req_data[i*DATA_SIZE +: DATA_SIZE]
//   req_last [N]       current word of producer i ends its packet
//   ack      [N]       one-hot, word of producer i consumed this cycle
//   gnt      [N]       one-hot registered grant, 0 when idle
//   fifo_full          Async_fifo full flag
//   wr_en, wr_data     Async_fifo write interface (wr_data=0 when no write)
//   busy               1 while in XFER
//   dbg_state          current FSM state
//
// Configuration macro: ARB_FIXED_PRIO_EN
//   defined   -> lowest requesting index wins in IDLE, no rotation pointer
//   undefined -> round-robin starting after the last released producer
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                           wclk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             ack,
    output logic [NUM_REQ-1:0]             gnt,
    input  logic                           fifo_full,
    output logic                           wr_en,
    output logic [DATA_SIZE-1:0]           wr_data,
    output logic                           busy,
    output arb_state_e                     dbg_state
);

    localparam int PTR_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(BURST_LEN + 1);
    // Count value of the final word in a full-length burst.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    arb_state_e           r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [CNT_W-1:0]     r_burst_cnt;

    logic [PTR_W-1:0]     w_pick_ptr;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic                 w_pick_valid;
    logic [NUM_REQ-1:0]   w_ack;
    logic                 w_wr_en;
    logic [DATA_SIZE-1:0] w_wr_data;
    logic                 w_last;
    logic                 w_burst_end;
    logic                 w_withdraw;
    logic                 w_release;

`ifdef ARB_FIXED_PRIO_EN
    // Searching from index 0 makes the picker a plain priority encoder.
    assign w_pick_ptr = '0;
`else
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_next_ptr;

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) begin
                w_gnt_idx = PTR_W'(i);
            end
        end
    end

    assign w_next_ptr = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                           : w_gnt_idx + PTR_W'(1);
    assign w_pick_ptr = r_ptr;
`endif

    arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (w_pick_ptr),
        .o_winner (w_pick_oh),
        .o_valid  (w_pick_valid)
    );

    // r_gnt is zero outside XFER, so the state qualifier is belt-and-braces.
    assign w_ack = ((r_state == ST_XFER) && !fifo_full) ? (r_gnt & req) : '0;
    assign w_wr_en = |w_ack;

    always_comb begin
        w_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ack[i]) begin
                w_wr_data = req_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign w_last      = |(w_ack & req_last);
    assign w_burst_end = (r_burst_cnt == LAST_CNT);
    // Granted producer dropped its valid: give the port up even under full.
    assign w_withdraw  = (r_state == ST_XFER) && ((r_gnt & req) == '0);
    assign w_release   = w_withdraw || (w_wr_en && (w_last || w_burst_end));

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_burst_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
            r_ptr       <= '0;
`endif
        end else if (r_state == ST_IDLE) begin
            if (w_pick_valid) begin
                r_gnt       <= w_pick_oh;
                r_burst_cnt <= '0;
                r_state     <= ST_XFER;
            end
        end else begin
            if (w_release) begin
                r_gnt       <= '0;
                r_burst_cnt <= '0;
                r_state     <= ST_IDLE;
`ifndef ARB_FIXED_PRIO_EN
                r_ptr       <= w_next_ptr;
`endif
            end else if (w_wr_en) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
        end
    end

    assign ack       = w_ack;
    assign gnt       = r_gnt;
    assign wr_en     = w_wr_en;
    assign wr_data   = w_wr_data;
    assign busy      = (r_state == ST_XFER);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed steps followed by a random phase. Producers are word queues
//   ({last,data}); a transaction-level model of the arbiter (owner, rotation
//   start, words in current burst) predicts every output each cycle, and
//   logs of observed grants/writes are compared to expected lists.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic              wclk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      ack;
  logic [N-1:0]      gnt;
  logic              fifo_full;
  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic              busy;
  arb_state_e        dbg_state;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .BURST_LEN(BL)) dut (
    .wclk(wclk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .req_last(req_last), .ack(ack), .gnt(gnt), .fifo_full(fifo_full),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  logic [DW:0]   prod_q [N][$];
  logic [N-1:0]  wd_mask;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_log[$];
  int            gnt_log[$];
  int            gnt_wr_log[$];
  int            exp_gnt_q[$];
  int            exp_cnt_q[$];
  logic [N-1:0]  prev_gnt;
  int            cur_wr;
  int            full_writes;

  // model
  int            m_owner;
  int            m_ptr;
  int            m_cnt;
  logic [N-1:0]  e_gnt;
  logic [N-1:0]  e_ack;
  logic          e_wr;
  logic [DW-1:0] e_data;
  logic          e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pick(input logic [N-1:0] r);
    int base;
    int w;
    w = -1;
`ifdef ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = m_ptr;
`endif
    for (int k = N - 1; k >= 0; k--) begin
      if (r[(base + k) % N]) w = (base + k) % N;
    end
    return w;
  endfunction

  task automatic model_outputs();
    e_gnt = '0; e_ack = '0; e_wr = 1'b0; e_data = '0; e_busy = 1'b0;
    if (m_owner >= 0) begin
      e_busy = 1'b1;
      e_gnt[m_owner] = 1'b1;
      if (req[m_owner] && !fifo_full) begin
        e_ack[m_owner] = 1'b1;
        e_wr = 1'b1;
        e_data = req_data[m_owner*DW +: DW];
      end
    end
  endtask

  task automatic model_advance();
    int w;
    logic rel;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      w = m_pick(req);
      if (w >= 0) begin m_owner = w; m_cnt = 0; end
    end else begin
      rel = !req[m_owner] || (e_wr && (req_last[m_owner] || (m_cnt + 1 == BL)));
      if (e_wr) void'(prod_q[m_owner].pop_front());
      if (rel) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
      end else if (e_wr) begin
        m_cnt++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    logic [DW:0] wv;
    for (int i = 0; i < N; i++) begin
      if (prod_q[i].size() > 0) begin
        wv = prod_q[i][0];
        req[i] = ~wd_mask[i];
        req_data[i*DW +: DW] = wv[DW-1:0];
        req_last[i] = wv[DW];
      end else begin
        req[i] = 1'b0;
        req_data[i*DW +: DW] = DW'($urandom);
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic push_word(input int p, input logic last, input logic [DW-1:0] d);
    prod_q[p].push_back({last, d});
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += prod_q[i].size();
    return s;
  endfunction

  // One clock: predict, check at negedge, advance model at posedge, re-drive.
  task automatic step();
    int gi;
    model_outputs();
    @(negedge wclk);
    chk("gnt",       32'(gnt),       32'(e_gnt));
    chk("ack",       32'(ack),       32'(e_ack));
    chk("wr_en",     32'(wr_en),     32'(e_wr));
    chk("wr_data",   32'(wr_data),   32'(e_data));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("dbg_state", 32'(dbg_state), 32'(e_busy));
    if (gnt !== prev_gnt) begin
      if (prev_gnt != '0) gnt_wr_log.push_back(cur_wr);
      if (gnt != '0) begin
        gi = -1;
        for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
        gnt_log.push_back(gi);
      end
      cur_wr = 0;
    end
    if (wr_en === 1'b1) begin
      cur_wr++;
      wr_log.push_back(wr_data);
      if (fifo_full) full_writes++;
    end
    prev_gnt = gnt;
    @(posedge wclk);
    model_advance();
    #1;
    drive_inputs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pending() > 0 || m_owner >= 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", 32'(pending()), 32'd0);
    step();  // idle cycle closes the last grant segment
  endtask

  task automatic clear_logs();
    wr_log.delete(); gnt_log.delete(); gnt_wr_log.delete();
    exp_q.delete(); exp_gnt_q.delete(); exp_cnt_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_data(input string tag);
    chk({tag, "_nwords"}, 32'(wr_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      chk({tag, "_word"}, 32'(wr_log[i]), 32'(exp_q[i]));
  endtask

  task automatic check_grants(input string tag);
    chk({tag, "_ngrants"}, 32'(gnt_log.size()), 32'(exp_gnt_q.size()));
    for (int i = 0; i < exp_gnt_q.size() && i < gnt_log.size(); i++)
      chk({tag, "_owner"}, 32'(gnt_log[i]), 32'(exp_gnt_q[i]));
    for (int i = 0; i < exp_cnt_q.size() && i < gnt_wr_log.size(); i++)
      chk({tag, "_burst"}, 32'(gnt_wr_log[i]), 32'(exp_cnt_q[i]));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit started;
    bit done;
    int stall_left;
    int n;
    rst_n = 1'b0; fifo_full = 1'b0; wd_mask = '0;
    req = '0; req_data = '0; req_last = '0;
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    prev_gnt = '0; cur_wr = 0; full_writes = 0;

    // Step 1/2: reset with all requesting, then round-robin bursts
    for (int i = 0; i < N; i++)
      for (int k = 0; k < ((i == 0) ? 8 : 4); k++)
        push_word(i, 1'b0, DW'(i * 16 + k));
    drive_inputs();
    step();
    step();
    rst_n = 1'b1;
    clear_logs();
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < 8; k++) exp_q.push_back(DW'(k));
    for (int i = 1; i < N; i++) for (int k = 0; k < 4; k++) exp_q.push_back(DW'(i * 16 + k));
    exp_gnt_q = '{0, 0, 1, 2, 3};
`else
    for (int i = 0; i < N; i++) for (int k = 0; k < 4; k++) exp_q.push_back(DW'(i * 16 + k));
    for (int k = 4; k < 8; k++) exp_q.push_back(DW'(k));
    exp_gnt_q = '{0, 1, 2, 3, 0};
`endif
    exp_cnt_q = '{4, 4, 4, 4, 4};
    drain(200);
    check_data("rr");
    check_grants("rr");

    // Step 3: packet end on 2nd word of producer 2
    clear_logs();
    push_word(2, 1'b0, 8'hA0); push_word(2, 1'b1, 8'hA1); push_word(2, 1'b0, 8'hA2);
    drive_inputs();
    exp_q = '{8'hA0, 8'hA1, 8'hA2};
    exp_gnt_q = '{2, 2};
    exp_cnt_q = '{2, 1};
    drain(50);
    check_data("last");
    check_grants("last");

    // Rotation start after producer 2 released: 0,1,3 requesting
    clear_logs();
    push_word(0, 1'b1, 8'hB0); push_word(1, 1'b1, 8'hB1); push_word(3, 1'b1, 8'hB3);
    drive_inputs();
`ifdef ARB_FIXED_PRIO_EN
    exp_gnt_q = '{0, 1, 3};
`else
    exp_gnt_q = '{3, 0, 1};
`endif
    exp_cnt_q = '{1, 1, 1};
    drain(50);
    check_grants("ptr");

    // Step 4: backpressure for 5 cycles after the 2nd word
    clear_logs();
    for (int k = 0; k < 4; k++) push_word(0, 1'b0, DW'(8'h10 + k));
    drive_inputs();
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    exp_gnt_q = '{0};
    exp_cnt_q = '{4};
    started = 0; stall_left = 0; n = 0; full_writes = 0;
    while ((pending() > 0 || m_owner >= 0) && n < 60) begin
      if (!started && wr_log.size() == 2) begin started = 1; stall_left = 5; end
      fifo_full = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      step();
      n++;
    end
    fifo_full = 1'b0;
    chk("stall_left", 32'(pending()), 32'd0);
    step();
    chk("stall_writes", 32'(full_writes), 32'd0);
    check_data("stall");
    check_grants("stall");

    // Step 5a: producer 1 withdraws after its first word
    clear_logs();
    for (int k = 0; k < 3; k++) push_word(1, 1'b0, DW'(8'h50 + k));
    drive_inputs();
    exp_q = '{8'h50, 8'h51, 8'h52};
    exp_gnt_q = '{1, 1};
    exp_cnt_q = '{1, 2};
    done = 0; n = 0;
    while ((pending() > 0 || m_owner >= 0) && n < 60) begin
      if (!done && wr_log.size() == 1) begin
        done = 1;
        wd_mask[1] = 1'b1;
        drive_inputs();
        step();
        wd_mask = '0;
        drive_inputs();
      end
      step();
      n++;
    end
    chk("wd_left", 32'(pending()), 32'd0);
    step();
    check_data("withdraw");
    check_grants("withdraw");

    // Step 5b: asynchronous reset in the middle of a burst
    clear_logs();
    for (int k = 0; k < 4; k++) push_word(3, 1'b0, DW'(8'h60 + k));
    drive_inputs();
    n = 0;
    while (wr_log.size() < 1 && n < 20) begin step(); n++; end
    chk("pre_rst_words", 32'(wr_log.size()), 32'd1);
    #2;
    rst_n = 1'b0;
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    #1;
    chk("arst_gnt",   32'(gnt),     32'd0);
    chk("arst_ack",   32'(ack),     32'd0);
    chk("arst_wr_en", 32'(wr_en),   32'd0);
    chk("arst_data",  32'(wr_data), 32'd0);
    chk("arst_busy",  32'(busy),    32'd0);
    step();
    step();
    rst_n = 1'b1;
    clear_logs();
    exp_q = '{8'h61, 8'h62, 8'h63};
    exp_gnt_q = '{3};
    exp_cnt_q = '{3};
    drain(50);
    check_data("arst");
    check_grants("arst");

    // Producers 1 and 3 both busy: fixed priority starves 3 until 1 is done
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      push_word(1, 1'b0, DW'(8'h70 + k));
      push_word(3, 1'b0, DW'(8'h80 + k));
    end
    drive_inputs();
`ifdef ARB_FIXED_PRIO_EN
    exp_gnt_q = '{1, 1, 3, 3};
`else
    exp_gnt_q = '{1, 3, 1, 3};
`endif
    exp_cnt_q = '{4, 4, 4, 4};
    drain(100);
    check_grants("pair");

    // Random phase: random arrivals, packet ends and backpressure
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) < 3)
        push_word($urandom_range(0, N - 1), ($urandom_range(0, 3) == 0), DW'($urandom));
      fifo_full = ($urandom_range(0, 3) == 0);
      drive_inputs();
      step();
    end
    fifo_full = 1'b0;
    drive_inputs();
    drain(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
